// File: rtl/booth_prod_acc_pkg.sv
// Shared definitions for the Booth product accumulator.
//   PW_DEF      : default product width (matches the multiplier result width)
//   state_t     : accumulator FSM state (ACC collecting, HOLD presenting a result)
//   sat_max/min : saturation limits for an AW-bit signed accumulator,
//                 returned in 64 bits; callers keep the low AW bits
//   ext_bits    : number of sign bits needed to widen a PW operand to AW
package booth_pkg;

  localparam int PW_DEF = 13;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Largest positive value of an aw-bit signed number: 2^(aw-1)-1.
  function automatic logic [63:0] sat_max(input int aw);
    return (64'd1 << (aw - 1)) - 64'd1;
  endfunction

  // Most negative aw-bit value; the bitwise complement of the maximum
  // has the low aw bits equal to 1000...0.
  function automatic logic [63:0] sat_min(input int aw);
    return ~sat_max(aw);
  endfunction

  function automatic int ext_bits(input int aw, input int pw);
    return aw - pw;
  endfunction

endpackage

// File: rtl/booth_prod_acc_if.sv
// Stream bundle between the multiplier, the accumulator and the result sink.
//   in_valid/in_ready/in_prod/in_last     : product stream into the accumulator
//   out_valid/out_ready/out_sum/
//   out_count/out_ovf                     : result stream out of the accumulator
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both 1. The source keeps valid and its payload
// stable until that edge; ready may depend combinationally on the other side.
// Modport slave is the accumulator's view, master is the producer/sink view.
interface booth_prod_acc_if #(
  parameter int PW = 13,
  parameter int AW = 20,
  parameter int CW = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  modport master (
    output in_valid,
    output in_prod,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_count,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_count,
    output out_ovf
  );

endinterface

// File: rtl/booth_prod_acc_sat_add.sv
// Saturating signed adder: a (AW bits) + sign-extended b (PW bits).
//   a    : current accumulator value
//   b    : signed product
//   sum  : result clamped to the AW-bit signed range
//   ovf  : 1 when the true sum did not fit and was clamped
// Purely combinational.
module sat_add
  import booth_pkg::*;
#(
  parameter int AW = 20,
  parameter int PW = PW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  localparam int          EXT   = ext_bits(AW, PW);
  localparam logic [63:0] MAX64 = sat_max(AW);
  localparam logic [63:0] MIN64 = sat_min(AW);

  logic [AW:0] wide;

  // One guard bit: with both operands sign-extended to AW+1 bits the sum
  // cannot wrap, so a disagreement between the top two bits means overflow.
  assign wide = {a[AW-1], a} + {{(EXT + 1){b[PW-1]}}, b};
  assign ovf  = wide[AW] ^ wide[AW-1];

  always_comb begin
    sum = wide[AW-1:0];
    if (ovf) begin
      // Bit AW carries the true sign of the unclamped result.
      sum = wide[AW] ? MIN64[AW-1:0] : MAX64[AW-1:0];
    end
  end

endmodule

// File: rtl/booth_prod_acc.sv
// Booth product accumulator: sums signed products from the multiplier into
// a wider saturating accumulator and emits one result per group.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : product input stream and result output stream (slave view)
//   state_dbg : current FSM state, for observation only
// A group closes after NACC products or on a product marked in_last. The
// result appears one cycle after the closing product and is held until the
// sink takes it. While a result is held, in_ready follows out_ready so a new
// group can start on the same edge that the result leaves.
module booth_prod_acc
  import booth_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int AW   = 20,
  parameter int NACC = 4,
  parameter int CW   = 4
) (
  input  logic clk,
  input  logic rst_n,
  booth_prod_acc_if.slave bus,
  output state_t state_dbg
);

  localparam logic [CW-1:0] NACC_C = CW'(NACC);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t        state;
  state_t        state_n;

  logic [AW-1:0] acc;
  logic [CW-1:0] count;
  logic          ovf;

  logic [AW-1:0] out_sum_q;
  logic [CW-1:0] out_count_q;
  logic          out_ovf_q;

  // Holds in_ready low until the first edge after reset is released.
  logic          rdy_en;

  logic [AW-1:0] add_base;
  logic [AW-1:0] add_sum;
  logic          add_ovf;

  logic          in_ready_c;
  logic          out_valid_c;
  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] cnt_n;
  logic          ovf_n;
  logic          close;

  // A product taken while a result is held seeds a fresh group, so the
  // adder starts from zero instead of the finished group's sum.
  assign add_base = (state == HOLD) ? '0 : acc;

  sat_add #(
    .AW(AW),
    .PW(PW)
  ) u_add (
    .a  (add_base),
    .b  (bus.in_prod),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Next-state and handshake decode.
  always_comb begin
    out_valid_c = 1'b0;
    in_ready_c  = 1'b0;
    in_xfer     = 1'b0;
    out_xfer    = 1'b0;
    cnt_n       = '0;
    ovf_n       = 1'b0;
    close       = 1'b0;
    state_n     = state;

    out_valid_c = (state == HOLD);
    in_ready_c  = rdy_en & ((state == ACC) | bus.out_ready);
    in_xfer     = bus.in_valid & in_ready_c;
    out_xfer    = out_valid_c & bus.out_ready;

    cnt_n = (state == HOLD) ? ONE_C : (count + ONE_C);
    ovf_n = ((state == HOLD) ? 1'b0 : ovf) | add_ovf;
    close = (cnt_n == NACC_C) | bus.in_last;

    // In HOLD an input transfer implies an output transfer, because
    // in_ready is gated by out_ready there.
    if (in_xfer) begin
      state_n = close ? HOLD : ACC;
    end else if (out_xfer) begin
      state_n = ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en      <= 1'b0;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (in_xfer) begin
        acc   <= add_sum;
        count <= cnt_n;
        ovf   <= ovf_n;
        // The closing product's result is captured on the same edge, so
        // out_valid rises one cycle after the closing transfer.
        if (close) begin
          out_sum_q   <= add_sum;
          out_count_q <= cnt_n;
          out_ovf_q   <= ovf_n;
        end
      end else if (out_xfer) begin
        acc   <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
  assign state_dbg     = state;

endmodule

// File: doc/booth_prod_acc.md
Name: booth_prod_acc

Overview:
- Downstream consumer of the radix-4 Booth multiplier pipeline.
- Accepts the multiplier's signed 13-bit products as a valid/ready stream and accumulates them into a wider signed sum with saturation.
- Emits one accumulated result per group of NACC products, or fewer when the producer marks a group end early.
- Forms the MAC back-end: multiplier feeds it, result sink drains it.

Parameters:
PW, 13, product width (signed two's complement), matches multiplier result width
AW, 20, accumulator/output width (signed), AW > PW
NACC, 4, products per group (1..15)
CW, 4, count width, must hold NACC

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  product valid from multiplier stage
in_ready  output  1  block can accept a product this cycle
in_prod  input  PW  signed product
in_last  input  1  product closes current group regardless of count
out_valid  output  1  accumulated result available
out_ready  input  1  sink accepts result
out_sum  output  AW  signed saturated group sum
out_count  output  CW  number of products in the emitted group
out_ovf  output  1  saturation occurred anywhere in the group (sticky per group)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACC; acc=0; count=0; ovf=0.
  - out_valid=0; out_sum=0; out_count=0; out_ovf=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first edge after release.
- Handshakes:
  - Input transfer: in_valid & in_ready at posedge.
  - Output transfer: out_valid & out_ready at posedge.
  - While out_valid=1, out_sum, out_count and out_ovf hold stable until transferred.
- State ACC:
  - in_ready=1; out_valid=0.
  - On input transfer: acc <= sat(acc + sext(in_prod)); count <= count+1; ovf <= ovf | overflow.
  - If count+1==NACC or in_last=1: state goes to HOLD.
  - Entering HOLD registers out_sum, out_count and out_ovf from the new values in the same edge, so latency is 1 cycle from the closing product to out_valid.
- State HOLD:
  - out_valid=1; in_ready=out_ready (combinational pass-through; no bubble when the sink is ready).
  - Output transfer without input transfer: acc=0, count=0, ovf=0, state goes to ACC.
  - Output transfer with simultaneous input transfer: a new group is seeded with acc=sext(in_prod), count=1, ovf=0.
    - If NACC==1 or in_last=1, stay in HOLD with the new result registered.
    - Otherwise go to ACC.
  - out_ready=0: in_ready=0, everything holds.
- Arithmetic:
  - Sum is computed at AW+1 bits.
  - Overflow when bit AW differs from bit AW-1.
  - On overflow, clamp to +(2^(AW-1)-1) or -(2^(AW-1)) by sign of bit AW, and set the overflow flag.
  - Once saturated, further additions continue from the clamped value.
- in_last with count=0 (first product of a group) closes a 1-product group.
- in_valid=0 never advances state; in_prod is ignored when in_valid=0.
- Reset mid-group discards the partial sum and any held result; there is no partial output.

Decomposition:
- Shared package booth_pkg holds:
  - PW default constant (13).
  - State enum {ACC, HOLD}.
  - Sign-extension and saturation limit constants as functions of AW.
- One sub-module: sat_add (AW-wide signed adder with PW-wide sign-extended operand, outputs clamped sum and overflow flag; purely combinational).
- FSM, counters and output registers live in booth_prod_acc.

Test Plan:
- Defaults. Products 100, -50, 2047, -4096 back-to-back, out_ready=1. Expect out_valid one cycle after the 4th transfer, with out_sum=-1999, out_count=4, out_ovf=0.
- in_last. Products 10, 20 with in_last on 20. Expect out_sum=30, out_count=2. The next group starts from 0.
- Saturation, AW=14. Products 4095 x4. Expect out_sum=8191, out_ovf=1. Mirror with -4096 x3 then 1: expect out_sum=-8191 (clamped to -8192 then +1), out_ovf=1.
- Backpressure. Hold out_ready=0 for 3 cycles after a result. Expect out_sum stable and in_ready=0. Then out_ready=1 with in_valid=1, in_prod=7: result transfers, new group has acc=7 and count=1, state ACC.
- Reset mid-operation. After 2 of 4 products, pulse rst_n low asynchronously (between edges). Expect out_valid=0, in_ready=0 immediately. After release, 4 products of 1 give out_sum=4, out_count=4.
- NACC=1. Stream 3, 5, 9 with out_ready=1 continuously. Expect one result per cycle (3, 5, 9), in_ready constantly 1, no bubbles.
